regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4: register address width; matches the register file write address.
REQ-002 Parameter DATA_W, default 32: write data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0_valid  input  1  ALU writeback request.
REQ-006 req0_addr  input  ADDR_W  ALU destination register.
REQ-007 req0_data  input  DATA_W  ALU result.
REQ-008 req0_ready  output  1  ALU request accepted this cycle.
REQ-009 req1_valid  input  1  load-unit writeback request.
REQ-010 req1_addr  input  ADDR_W  load destination register.
REQ-011 req1_data  input  DATA_W  load data.
REQ-012 req1_ready  output  1  load request accepted this cycle.
REQ-013 rd_addr  output  ADDR_W  register file write address; 0 means no write.
REQ-014 rd_data  output  DATA_W  register file write data.
REQ-015 cnt_clr  input  1  synchronous clear of conflict_cnt.
REQ-016 conflict_cnt  output  16  saturating count of contested cycles.

Function
REQ-017 The block SHALL share the single register file write port between two requesters.
REQ-018 Handshake: a transfer occurs when reqN_valid and reqN_ready are both high at a rising edge.
REQ-019 Once a requester asserts reqN_valid, it SHALL hold valid, addr and data stable until the transfer occurs.
REQ-020 reqN_ready SHALL be combinational from the valid inputs and the priority pointer, with no dependence on addr or data.
REQ-021 At most one ready SHALL be high per cycle, and ready SHALL never be high without the matching valid.
REQ-022 Arbitration with one valid requester: that requester is granted.
REQ-023 Arbitration with both requesters valid: the requester other than last_grant is granted (round-robin).
REQ-024 Arbitration with neither requester valid: nothing is granted.
REQ-025 last_grant SHALL update to the granted index on every grant and hold when nothing is granted.
REQ-026 Latency: data accepted at edge N SHALL appear on rd_addr/rd_data during cycle N+1, as a registered output stage.
REQ-027 rd_addr SHALL return to 0 in any cycle following an edge with no grant.
REQ-028 rd_data SHALL hold its previous value when no grant occurs.
REQ-029 A granted request with addr 0 SHALL consume the slot and update last_grant, but SHALL drive rd_addr=0 so no write occurs.
REQ-030 conflict_cnt SHALL increment by 1 on each edge where req0_valid and req1_valid are both high.
REQ-031 conflict_cnt SHALL saturate at 0xFFFF.
REQ-032 cnt_clr SHALL take priority over the increment in the same cycle.
REQ-033 The block SHALL add no back-pressure beyond arbitration, so a lone requester is accepted every cycle (full throughput).

Reset
REQ-034 While rst is high, the following SHALL hold: rd_addr=0, rd_data=0, conflict_cnt=0, last_grant=1 (req0 wins the first tie), both ready outputs low.
REQ-035 Reset asserted mid-transfer SHALL discard any registered output, so no register file write occurs for it.
REQ-036 Requesters SHALL re-present any un-handshaken request after reset.
REQ-037 The first edge after rst deasserts SHALL arbitrate normally.

Structure
REQ-038 A shared package SHALL hold REGFILE_ADDR_W, REGFILE_DATA_W, NUM_WB_REQ=2 and the requester index constants (WB_ALU=0, WB_LOAD=1).
REQ-039 One sub-module SHALL be used: rr_arb2, a 2-way round-robin grant generator with its own last_grant register.
REQ-040 The output register and conflict counter SHALL remain in the top module.

Verification
REQ-041 Lone ALU request: req0 valid, addr=5, data=0xDEADBEEF for 1 cycle -> req0_ready=1 that cycle; next cycle rd_addr=5, rd_data=0xDEADBEEF; following cycle rd_addr=0.
REQ-042 Contention after reset: both requesters valid (req0 addr 3 / req1 addr 7) held for 4 cycles -> grants alternate req0, req1, req0, req1; conflict_cnt=4 (counting stops only when one requester drops).
REQ-043 Addr-0 discard: req1 valid with addr=0, data=0x1234 -> req1_ready=1 and last_grant=1; rd_addr stays 0 the next cycle.
REQ-044 Counter saturation and clear: force both valid for 65540 cycles -> conflict_cnt=0xFFFF; pulse cnt_clr with both still valid -> conflict_cnt=0 the next cycle.
REQ-045 Reset mid-operation: assert rst asynchronously between the accept edge and the output cycle -> rd_addr=0 immediately, and no write is issued.
REQ-046 Random traffic with a register file model -> every handshaken nonzero-addr request is written exactly once, in grant order, and readys are never both high.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: register file geometry and writeback requester indices
package regfile_wb_arbiter_pkg;
  localparam int REGFILE_ADDR_W = 4;
  localparam int REGFILE_DATA_W = 32;
  localparam int NUM_WB_REQ = 2;
  localparam int WB_ALU = 0;
  localparam int WB_LOAD = 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin grant generator holding its own last_grant pointer
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_WB_REQ-1:0] valid,
  output logic [NUM_WB_REQ-1:0] grant
);
  logic last_grant;
  // on a tie the requester that did not win last time is granted
  always_comb begin
    grant[WB_ALU]  = !rst && valid[WB_ALU] && (!valid[WB_LOAD] || last_grant);
    grant[WB_LOAD] = !rst && valid[WB_LOAD] && (!valid[WB_ALU] || !last_grant);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[WB_LOAD];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load writeback
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int DATA_W = REGFILE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              cnt_clr,
  output logic [15:0]       conflict_cnt
);
  logic [NUM_WB_REQ-1:0] grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .valid({req1_valid, req0_valid}),
    .grant(grant)
  );
  always_comb begin
    req0_ready = grant[WB_ALU];
    req1_ready = grant[WB_LOAD];
    sel_addr   = grant[WB_LOAD] ? req1_addr : req0_addr;
    sel_data   = grant[WB_LOAD] ? req1_data : req0_data;
  end
  // address 0 still flows through, which the register file treats as no write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      rd_addr <= |grant ? sel_addr : '0;
      if (|grant) rd_data <= sel_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) conflict_cnt <= '0;
    else if (cnt_clr) conflict_cnt <= '0;
    else if (req0_valid && req1_valid && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 16'd1;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the writeback arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready, cnt_clr;
  logic [3:0] req0_addr, req1_addr, rd_addr;
  logic [31:0] req0_data, req1_data, rd_data;
  logic [15:0] conflict_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic lg, g0, g1;
    logic [3:0] exp_addr;
    logic [31:0] exp_data;
    rst = 1'b1;
    {req0_valid, req1_valid, cnt_clr} = '0;
    {req0_addr, req1_addr, req0_data, req1_data} = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_last_grant", dut.u_arb.last_grant, 1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_readys", {req1_ready, req0_ready}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // lone ALU request, first edge after reset
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("lone_readys", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("lone_rd_addr", rd_addr, 5);
    chk("lone_rd_data", rd_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("idle_rd_addr", rd_addr, 0);
    chk("idle_rd_data_hold", rd_data, 32'hDEADBEEF);
    // contention after reset
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 32'hA0A0A0A0;
    req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 32'hB1B1B1B1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_readys", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      chk("tie_rd_addr", rd_addr, (i % 2 == 0) ? 3 : 7);
      chk("tie_rd_data", rd_data, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("tie_cnt", conflict_cnt, 4);
    @(negedge clk);
    chk("tie_cnt_stop", conflict_cnt, 4);
    chk("tie_rd_addr_idle", rd_addr, 0);
    // ALU wins alone, then an addr-0 load is granted and moves the pointer back
    req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 32'h55;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("pre_lg", dut.u_arb.last_grant, 0);
    req1_valid = 1'b1; req1_addr = 4'd0; req1_data = 32'h1234;
    #1;
    chk("a0_readys", {req1_ready, req0_ready}, 2'b10);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("a0_lg", dut.u_arb.last_grant, 1);
    chk("a0_rd_addr", rd_addr, 0);
    // async reset between accept edge and output cycle
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 32'h99;
    @(posedge clk);
    #1;
    chk("mid_rd_addr_pre", rd_addr, 9);
    req0_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rd_addr", rd_addr, 0);
    chk("mid_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rd_addr_after", rd_addr, 0);
    // saturation and clear priority
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (65540) @(negedge clk);
    chk("sat_cnt", conflict_cnt, 16'hFFFF);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_cnt", conflict_cnt, 0);
    @(negedge clk);
    chk("clr_cnt_resume", conflict_cnt, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // random traffic against a reference arbiter and expected write stream
    do_reset();
    lg = 1'b1;
    exp_addr = '0;
    for (int c = 0; c < 300; c++) begin
      chk("rnd_rd_addr", rd_addr, exp_addr);
      if (exp_addr != 0) chk("rnd_rd_data", rd_data, exp_data);
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_addr = 4'($urandom); req0_data = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1; req1_addr = 4'($urandom); req1_data = $urandom;
      end
      g0 = req0_valid && (!req1_valid || lg);
      g1 = req1_valid && (!req0_valid || !lg);
      #1;
      chk("rnd_readys", {req1_ready, req0_ready}, {g1, g0});
      exp_addr = g0 ? req0_addr : g1 ? req1_addr : 4'd0;
      if (g0 || g1) exp_data = g0 ? req0_data : req1_data;
      if (g0 || g1) lg = g1;
      @(negedge clk);
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
    end
    chk("rnd_final_rd_addr", rd_addr, exp_addr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
